// File: rtl/nn_mlp_seq.sv
// Time-multiplexed 3-layer quantised MLP: one shared signed MAC walks every neuron of
// each layer in turn, reading weights and biases from an internal register file.
module nn_mlp_seq #(
  parameter int N_INPUTS    = 4,
  parameter int N_LAYER_1   = 4,
  parameter int N_LAYER_2   = 4,
  parameter int N_OUT       = 2,
  parameter int WEIGHT_BITS = 3,
  parameter int ACT_BITS    = 3,
  parameter int SHIFT       = 0,
  parameter int ACC_BITS    = 16,
  parameter int ADDR_BITS   = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic signed [WEIGHT_BITS-1:0] wr_data,
  output logic                          wr_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_INPUTS-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT-1:0]              out_data,
  output logic                          busy
);

  localparam int NW      = N_INPUTS*N_LAYER_1 + N_LAYER_1*N_LAYER_2 + N_LAYER_2*N_OUT;
  localparam int NB      = N_LAYER_1 + N_LAYER_2 + N_OUT;
  localparam int NWB     = NW + NB;
  localparam int DEPTH   = 2**ADDR_BITS;
  localparam int B_W2    = N_INPUTS*N_LAYER_1;
  localparam int B_W3    = B_W2 + N_LAYER_1*N_LAYER_2;
  localparam int B_B1    = NW;
  localparam int B_B2    = NW + N_LAYER_1;
  localparam int B_B3    = B_B2 + N_LAYER_2;
  localparam int ACT_MAX = 2**ACT_BITS - 1;
  localparam int CW      = 8;

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic signed [WEIGHT_BITS-1:0] file_q [DEPTH];
  logic [N_INPUTS-1:0]          x_q, x_d;
  logic [ACT_BITS-1:0]          act1_q [N_LAYER_1];
  logic [ACT_BITS-1:0]          act1_d [N_LAYER_1];
  logic [ACT_BITS-1:0]          act2_q [N_LAYER_2];
  logic [ACT_BITS-1:0]          act2_d [N_LAYER_2];
  logic signed [ACC_BITS-1:0]   acc_q, acc_d;
  logic [CW-1:0]                k_q, k_d, n_q, n_d;
  logic [N_OUT-1:0]             out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         wr_err_q, wr_err_d;
  logic                         we;

  logic [CW-1:0]                fan, nlast;
  int                           fi, wbase, bbase;
  logic [ADDR_BITS-1:0]         w_addr, b_addr;
  logic [ACT_BITS-1:0]          x_cur;
  logic signed [ACT_BITS:0]     x_s;
  logic signed [WEIGHT_BITS-1:0] w_cur, b_cur;
  logic signed [ACC_BITS-1:0]   prod, bias_ext;

  // Hidden activation: shift, then clamp into [0, 2^ACT_BITS-1].
  function automatic logic [ACT_BITS-1:0] clamp_act(input logic signed [ACC_BITS-1:0] a);
    logic signed [ACC_BITS-1:0] s;
    s = a >>> SHIFT;
    if (s[ACC_BITS-1] || s == '0)
      return '0;
    else if (s > ACC_BITS'(ACT_MAX))
      return ACT_BITS'(ACT_MAX);
    else
      return s[ACT_BITS-1:0];
  endfunction

  assign in_ready  = (state_q == S_IDLE) && reset;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wr_err    = wr_err_q;
  assign we        = wr_en && (state_q == S_IDLE) && (int'(wr_addr) < NWB);

  // Operand selection for the shared MAC
  always_comb begin
    fan   = CW'(N_INPUTS);
    nlast = CW'(N_LAYER_1 - 1);
    fi    = N_INPUTS;
    wbase = 0;
    bbase = B_B1;
    x_cur = '0;
    case (state_q)
      S_L2: begin
        fan = CW'(N_LAYER_1); nlast = CW'(N_LAYER_2 - 1);
        fi  = N_LAYER_1;      wbase = B_W2; bbase = B_B2;
      end
      S_L3: begin
        fan = CW'(N_LAYER_2); nlast = CW'(N_OUT - 1);
        fi  = N_LAYER_2;      wbase = B_W3; bbase = B_B3;
      end
      default: ;
    endcase
    case (state_q)
      S_L1: for (int i = 0; i < N_INPUTS; i++)
              if (k_q == CW'(i)) x_cur = ACT_BITS'(x_q[i]);
      S_L2: for (int i = 0; i < N_LAYER_1; i++)
              if (k_q == CW'(i)) x_cur = act1_q[i];
      S_L3: for (int i = 0; i < N_LAYER_2; i++)
              if (k_q == CW'(i)) x_cur = act2_q[i];
      default: ;
    endcase
    w_addr   = ADDR_BITS'(wbase + int'(n_q)*fi + int'(k_q));
    b_addr   = ADDR_BITS'(bbase + int'(n_q));
    w_cur    = file_q[w_addr];
    b_cur    = file_q[b_addr];
    x_s      = $signed({1'b0, x_cur});
    prod     = ACC_BITS'(w_cur) * ACC_BITS'(x_s);
    bias_ext = ACC_BITS'(b_cur);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    act1_d      = act1_q;
    act2_d      = act2_q;
    acc_d       = acc_q;
    k_d         = k_q;
    n_d         = n_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_err_d    = wr_en && ((state_q != S_IDLE) || (int'(wr_addr) >= NWB));
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = in_data;
          k_d     = '0;
          n_d     = '0;
          state_d = S_L1;
        end
      end
      S_L1, S_L2, S_L3: begin
        if (k_q == fan) begin
          // Writeback cycle: commit this neuron, then step neuron/layer
          case (state_q)
            S_L1: for (int i = 0; i < N_LAYER_1; i++)
                    if (n_q == CW'(i)) act1_d[i] = clamp_act(acc_q);
            S_L2: for (int i = 0; i < N_LAYER_2; i++)
                    if (n_q == CW'(i)) act2_d[i] = clamp_act(acc_q);
            default: for (int i = 0; i < N_OUT; i++)
                    if (n_q == CW'(i)) out_data_d[i] = !acc_q[ACC_BITS-1] && (acc_q != '0);
          endcase
          k_d = '0;
          if (n_q == nlast) begin
            n_d = '0;
            case (state_q)
              S_L1:    state_d = S_L2;
              S_L2:    state_d = S_L3;
              default: state_d = S_DONE;
            endcase
          end else begin
            n_d = n_q + CW'(1);
          end
        end else begin
          acc_d = (k_q == '0) ? bias_ext + prod : acc_q + prod;
          k_d   = k_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      act1_q      <= '{default: '0};
      act2_q      <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      act1_q      <= act1_d;
      act2_q      <= act2_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      n_q         <= n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      file_q <= '{default: '0};
    else if (we)
      file_q[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_nn_mlp_seq.sv
// Bench for nn_mlp_seq: fixed vectors on a hand-built file, hold/abort/write-error
// sequences, and random weight files checked against a layer-by-layer reference model.
module tb_nn_mlp_seq;
  localparam int NI  = 4;
  localparam int N1  = 4;
  localparam int N2  = 4;
  localparam int NO  = 2;
  localparam int NW  = NI*N1 + N1*N2 + N2*NO;
  localparam int NWB = NW + N1 + N2 + NO;
  localparam int LAT = N1*(NI+1) + N2*(N1+1) + NO*(N2+1) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [6:0] wr_addr = '0;
  logic signed [2:0] wr_data = '0;
  logic       wr_err;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic       busy;

  nn_mlp_seq #(
    .N_INPUTS(NI), .N_LAYER_1(N1), .N_LAYER_2(N2), .N_OUT(NO),
    .WEIGHT_BITS(3), .ACT_BITS(3), .SHIFT(0), .ACC_BITS(16), .ADDR_BITS(7)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mw[NWB];

  typedef struct {
    logic [3:0] x;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[6:0];
    wr_data = d[2:0];
    tick();
    wr_en = 1'b0;
    if (a < NWB) mw[a] = d;
  endtask

  task automatic clear_file();
    for (int a = 0; a < NWB; a++) wr(a, 0);
  endtask

  task automatic load_t2();
    clear_file();
    for (int k = 0; k < NI; k++) wr(k, 1);
    wr(NI*N1, 3);
    wr(NI*N1 + N1*N2, 1);
    wr(NW + N1 + N2, -4);
    wr(NI*N1 + N1*N2 + N2, -1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < LAT + 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [3:0] x, output logic [1:0] got);
    int lat;
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("latency", lat, LAT);
    got = out_data;
    handshake();
    check("in_ready_after_handshake", int'(in_ready), 1);
  endtask

  function automatic int hclamp(input int a);
    if (a <= 0) return 0;
    if (a > 7) return 7;
    return a;
  endfunction

  // Straight evaluation of the network from the shadow weight file.
  function automatic logic [1:0] model(input logic [3:0] x);
    int a0[NI];
    int a1[N1];
    int a2[N2];
    int acc;
    logic [1:0] r;
    for (int i = 0; i < NI; i++) a0[i] = int'(x[i]);
    for (int n = 0; n < N1; n++) begin
      acc = mw[NW + n];
      for (int k = 0; k < NI; k++) acc += mw[n*NI + k] * a0[k];
      a1[n] = hclamp(acc);
    end
    for (int n = 0; n < N2; n++) begin
      acc = mw[NW + N1 + n];
      for (int k = 0; k < N1; k++) acc += mw[NI*N1 + n*N1 + k] * a1[k];
      a2[n] = hclamp(acc);
    end
    for (int n = 0; n < NO; n++) begin
      acc = mw[NW + N1 + N2 + n];
      for (int k = 0; k < N2; k++) acc += mw[NI*N1 + N1*N2 + n*N2 + k] * a2[k];
      r[n] = (acc > 0);
    end
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] got;
    logic [3:0] xr;
    int lat, lat2;
    bit ok;

    for (int a = 0; a < NWB; a++) mw[a] = 0;
    tbl[0] = '{4'b1011, 2'b01};
    tbl[1] = '{4'b0000, 2'b00};
    tbl[2] = '{4'b0001, 2'b00};
    tbl[3] = '{4'b0011, 2'b01};
    tbl[4] = '{4'b1111, 2'b01};
    tbl[5] = '{4'b0100, 2'b00};

    // reset state
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_err", int'(wr_err), 0);
    check("rst_out_data", int'(out_data), 0);
    tick();
    reset = 1'b1;
    tick();
    check("in_ready_after_reset", int'(in_ready), 1);

    // T1: zero file
    run(4'b1011, got);
    check("t1_out", int'(got), 0);

    // T2/T3 table
    load_t2();
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].x, got);
      check($sformatf("t2_vec%0d", i), int'(got), int'(tbl[i].exp));
    end

    // T4: hold in DONE
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("t4_latency", lat, LAT);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!out_valid || out_data != 2'b01 || in_ready || !busy) ok = 1'b0;
    end
    check("t4_hold", int'(ok), 1);
    handshake();
    check("t4_idle_in_ready", int'(in_ready), 1);
    check("t4_idle_out_valid", int'(out_valid), 0);

    // T5: write during L2 is dropped
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    check("t5_busy_in_l2", int'(busy), 1);
    wr_en = 1'b1; wr_addr = 7'd0; wr_data = 3'b100;
    tick();
    wr_en = 1'b0;
    check("t5_wr_err_pulse", int'(wr_err), 1);
    tick();
    check("t5_wr_err_clear", int'(wr_err), 0);
    wait_out(lat2);
    check("t5_latency", lat2 + 27, LAT);
    check("t5_out", int'(out_data), 2'b01);
    handshake();
    wr(NWB, 1);
    check("t5_bad_addr_err", int'(wr_err), 1);
    tick();
    check("t5_bad_addr_err_clear", int'(wr_err), 0);
    run(4'b1011, got);
    check("t5_after_bad_addr", int'(got), 2'b01);

    // write in the same cycle as accept is used by that computation
    in_valid = 1'b1; in_data = 4'b0001;
    wr_en = 1'b1; wr_addr = 7'(NW + N1 + N2); wr_data = -3'sd2;
    tick();
    in_valid = 1'b0; wr_en = 1'b0;
    mw[NW + N1 + N2] = -2;
    check("same_cycle_wr_err", int'(wr_err), 0);
    wait_out(lat);
    check("same_cycle_latency", lat, LAT);
    check("same_cycle_out", int'(out_data), 2'b01);
    handshake();

    // random weight files against the model
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < NWB; a++) wr(a, int'($urandom_range(7)) - 4);
      for (int j = 0; j < 4; j++) begin
        xr = 4'($urandom_range(15));
        run(xr, got);
        check($sformatf("rand_r%0d_x%0h", r, xr), int'(got), int'(model(xr)));
      end
    end

    // T6: reset mid-computation
    load_t2();
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    reset = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_out_data", int'(out_data), 0);
    check("t6_wr_err", int'(wr_err), 0);
    check("t6_in_ready", int'(in_ready), 0);
    tick();
    reset = 1'b1;
    for (int a = 0; a < NWB; a++) mw[a] = 0;
    ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (out_valid || busy) ok = 1'b0;
    end
    check("t6_no_out_valid", int'(ok), 1);
    run(4'b1011, got);
    check("t6_file_cleared", int'(got), int'(model(4'b1011)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
